stream_mux: RTL and testbench

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/stream_mux_rr_arbiter.sv | 29 ++
 rtl/stream_mux.sv | 105 ++++++++++
 tb/tb_stream_mux.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream_mux block and its arbiter.
// The optional transfer counter (macro STREAM_MUX_STATS_EN) uses STATS_W.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin search: first requesting channel at or above ptr, wrapping at N_CH.
// Purely combinational; the pointer register lives in stream_mux.
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            grant_valid
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    // Walk the search window from the far end so the nearest request wins last.
    for (int k = N_CH - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (req[idx]) begin
        grant       = CH_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with fixed or round-robin selection
// and a single output register stage; macro STREAM_MUX_STATS_EN adds xfer_cnt.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   mode,
  input  logic [CH_W-1:0]        sel,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef STREAM_MUX_STATS_EN
  ,
  output logic [STATS_W-1:0]     xfer_cnt
`endif
);

  mode_e             mode_sel;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_grant;
  logic              rr_grant_valid;
  logic [CH_W-1:0]   grant;
  logic              grant_ok;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] grant_data;
  logic [CH_W-1:0]   ptr_next;

  assign mode_sel = mode_e'(mode);

  rr_arbiter #(
    .N_CH(N_CH),
    .CH_W(CH_W)
  ) u_arb (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .grant      (rr_grant),
    .grant_valid(rr_grant_valid)
  );

  // Fixed mode grants sel whether or not it is valid; out-of-range sel grants nobody.
  always_comb begin
    grant    = sel;
    grant_ok = int'(sel) < N_CH;
    if (mode_sel == MODE_RR) begin
      grant    = rr_grant;
      grant_ok = rr_grant_valid;
    end
  end

  assign can_accept = !out_valid || out_ready;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == grant) begin
        in_ready[i] = grant_ok && can_accept;
        grant_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept   = |(in_ready & in_valid);
  assign ptr_next = (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
        rr_ptr    <= ptr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_MUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (accept && (xfer_cnt != '1)) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a 4-channel instance driven from a vector table
// plus hand sequences, and a 5-channel instance for out-of-range select.
module tb_stream_mux;
  import stream_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [39:0] in_data1;
  logic [4:0]  in_valid1;
  logic [4:0]  in_ready1;
  logic        mode1;
  logic [2:0]  sel1;
  logic [7:0]  out_data1;
  logic [2:0]  out_ch1;
  logic        out_valid1;
  logic        out_ready1;

`ifdef STREAM_MUX_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_mux #(.N_CH(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef STREAM_MUX_STATS_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  stream_mux #(.N_CH(5), .DATA_W(8)) dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .mode     (mode1),
    .sel      (sel1),
    .out_data (out_data1),
    .out_ch   (out_ch1),
    .out_valid(out_valid1),
    .out_ready(out_ready1)
`ifdef STREAM_MUX_STATS_EN
    ,
    .xfer_cnt (xfer_cnt1)
`endif
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [7:0] d, input logic [1:0] ch);
    check({tag, " out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, " out_data"},  64'(out_data),  64'(d));
    check({tag, " out_ch"},    64'(out_ch),    64'(ch));
  endtask

  // Leaves the bench 1 time unit after a rising edge, ready to drive.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid   = 4'b0000;
    mode       = 1'b0;
    sel        = 2'd0;
    out_ready  = 1'b0;
    in_data1   = {8'h5A, 8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid1  = 5'b00000;
    mode1      = 1'b0;
    sel1       = 3'd0;
    out_ready1 = 1'b0;

    //            mode sel  valid    ordy  exp_ready  ov    data   ch
    vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'hA5, 2'd2};
    vecs[2]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[3]  = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    vecs[4]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[10] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[11] = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[12] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
    vecs[13] = '{1'b1, 2'd0, 4'b1010, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[14] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    vecs[15] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};

    do_reset();
    check_out("reset", 1'b0, 8'h00, 2'd0);
    check("reset in_ready", 64'(in_ready), 64'(4'b0001));
    check("reset dut5 out_valid", 64'(out_valid1), 64'(1'b0));

    for (int i = 0; i < 16; i++) begin
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check_out($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_data, vecs[i].exp_ch);
    end

    // Stall: hold for three cycles, then resume with no loss or duplicate.
    in_valid  = 4'b0000;
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall first in_ready", 64'(in_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    check_out("stall load", 1'b1, 8'h11, 2'd0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d in_ready", c), 64'(in_ready), 64'(4'b0000));
      @(posedge clk);
      #1;
      check_out($sformatf("stall%0d", c), 1'b1, 8'h11, 2'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("resume in_ready", 64'(in_ready), 64'(4'b0010));
    @(posedge clk);
    #1;
    check_out("resume1", 1'b1, 8'h22, 2'd1);
    @(negedge clk);
    check("resume2 in_ready", 64'(in_ready), 64'(4'b0100));
    @(posedge clk);
    #1;
    check_out("resume2", 1'b1, 8'hA5, 2'd2);

    // Mid-stream reset: output clears at once, search restarts at channel 0.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async reset", 1'b0, 8'h00, 2'd0);
    @(posedge clk);
    #1;
    check("in reset out_valid", 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post reset in_ready", 64'(in_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    check_out("post reset", 1'b1, 8'h11, 2'd0);
    in_valid  = 4'b0000;

    // Five channels: sel=4 is legal, sel=7 grants nobody and the output drains.
    mode1      = 1'b0;
    sel1       = 3'd4;
    in_valid1  = 5'b11111;
    out_ready1 = 1'b1;
    @(negedge clk);
    check("n5 sel4 in_ready", 64'(in_ready1), 64'(5'b10000));
    @(posedge clk);
    #1;
    check("n5 sel4 out_valid", 64'(out_valid1), 64'(1'b1));
    check("n5 sel4 out_data",  64'(out_data1),  64'(8'h5A));
    check("n5 sel4 out_ch",    64'(out_ch1),    64'(3'd4));
    sel1 = 3'd7;
    @(negedge clk);
    check("n5 sel7 in_ready", 64'(in_ready1), 64'(5'b00000));
    @(posedge clk);
    #1;
    check("n5 sel7 out_valid", 64'(out_valid1), 64'(1'b0));
    in_valid1 = 5'b00000;

`ifdef STREAM_MUX_STATS_EN
    do_reset();
    check("stats reset", 64'(xfer_cnt), 64'(16'h0000));
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stats count3", 64'(xfer_cnt), 64'(16'd3));
    repeat (69997) @(posedge clk);
    #1;
    check("stats saturate", 64'(xfer_cnt), 64'(16'hFFFF));
    in_valid = 4'b0000;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
